// File: rtl/jtopl_op_wr_sched_pkg.sv
// Shared definitions for the operator-register write scheduler.
//   - default geometry of the operator CSR (slots per revolution, slot width,
//     stage offsets)
//   - register group codes decoded from sel_addr[7:5]
//   - field-select record and FSM state type
//   - helpers: operator offset validity and offset-to-slot mapping
package jtopl_op_wr_sched_pkg;

  localparam int LEN_DEF    = 18;
  localparam int SLOT_W_DEF = 5;
  localparam int OFF_II_DEF = 1;
  localparam int OFF_IV_DEF = 3;

  localparam logic [2:0] GRP_MULT   = 3'd1;
  localparam logic [2:0] GRP_KSL_TL = 3'd2;
  localparam logic [2:0] GRP_AR_DR  = 3'd3;
  localparam logic [2:0] GRP_SL_RR  = 3'd4;
  localparam logic [2:0] GRP_WAV    = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  typedef struct packed {
    logic mult;
    logic ksl_tl;
    logic ar_dr;
    logic sl_rr;
    logic wav;
  } field_sel_t;

  // Operator offsets come in three blocks of six (0x00-0x05, 0x08-0x0D,
  // 0x10-0x15); the gaps at x6/x7 belong to no operator.
  function automatic logic op_off_valid(input logic [4:0] off);
    return (off <= 5'h15) && (off[2:0] <= 3'd5);
  endfunction

  // Slot index = block*6 + position, built as block*4 + block*2 + position.
  function automatic logic [4:0] op_tgt(input logic [4:0] off);
    return {1'b0, off[4:3], 2'b00} + {2'b00, off[4:3], 1'b0} + {2'b00, off[2:0]};
  endfunction

  function automatic field_sel_t grp_decode(input logic [2:0] grp);
    field_sel_t f;
    f = '0;
    case (grp)
      GRP_MULT:   f.mult   = 1'b1;
      GRP_KSL_TL: f.ksl_tl = 1'b1;
      GRP_AR_DR:  f.ar_dr  = 1'b1;
      GRP_SL_RR:  f.sl_rr  = 1'b1;
      GRP_WAV:    f.wav    = 1'b1;
      default:    f        = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/jtopl_op_wr_sched_slot_cnt.sv
// Free-running operator slot counter for the CSR revolution.
// Advances on cen, wraps at LEN-1, and provides a registered zero flag.
// slot_nx exposes the value the counter will load on the next clk so that
// callers can register outputs aligned with the new slot.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   cen        slot advance enable
//   slot       current slot 0..LEN-1
//   zero       high while slot == 0
//   slot_nx    next-slot value (combinational from slot and cen)
module jtopl_op_wr_sched_slot_cnt
  import jtopl_op_wr_sched_pkg::*;
#(
  parameter int LEN    = LEN_DEF,
  parameter int SLOT_W = SLOT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  output logic [SLOT_W-1:0] slot,
  output logic              zero,
  output logic [SLOT_W-1:0] slot_nx
);

  always_comb begin
    slot_nx = slot;
    if (cen) begin
      slot_nx = (slot == SLOT_W'(LEN - 1)) ? '0 : slot + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      zero <= 1'b1;
    end else begin
      slot <= slot_nx;
      zero <= (slot_nx == '0);
    end
  end

endmodule

// File: rtl/jtopl_op_wr_sched.sv
// Operator-register write scheduler for the OPL operator CSR.
// Latches CPU address/data writes, decodes operator registers 0x20-0xF5 and
// holds one accepted write pending for a full CSR revolution, raising stage
// strobes I/II/IV while the target operator sits at each stage.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cen                   slot advance enable (shared with the CSR)
//   wr_n, addr, din       CPU write strobe (active-low), addr/data select, data
//   busy                  operator write pending; further operator data dropped
//   slot, zero            current operator slot and slot==0 flag
//   dout                  latched data towards the CSR
//   up_mult..up_wav       field selects, level, held while busy
//   update_op_I/II/IV     stage strobes
//   up_other              one-clk pulse for non-operator data writes
//   sel_addr              latched address register
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no operator write pending; operator data writes are accepted
// ST_PEND | write pending; counting LEN cen-cycles before releasing
module jtopl_op_wr_sched
  import jtopl_op_wr_sched_pkg::*;
#(
  parameter int LEN    = LEN_DEF,
  parameter int SLOT_W = SLOT_W_DEF,
  parameter int OFF_II = OFF_II_DEF,
  parameter int OFF_IV = OFF_IV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              wr_n,
  input  logic              addr,
  input  logic [7:0]        din,
  output logic              busy,
  output logic [SLOT_W-1:0] slot,
  output logic              zero,
  output logic [7:0]        dout,
  output logic              up_mult,
  output logic              up_ksl_tl,
  output logic              up_ar_dr,
  output logic              up_sl_rr,
  output logic              up_wav,
  output logic              update_op_I,
  output logic              update_op_II,
  output logic              update_op_IV,
  output logic              up_other,
  output logic [7:0]        sel_addr
);

  localparam int SUM_W = SLOT_W + 1;

  // One extra bit so tgt+offset cannot overflow before the modulo.
  function automatic logic [SLOT_W-1:0] wrap_add(input logic [SLOT_W-1:0] base,
                                                 input int offs);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, base} + SUM_W'(offs);
    if (sum >= SUM_W'(LEN)) begin
      sum = sum - SUM_W'(LEN);
    end
    return sum[SLOT_W-1:0];
  endfunction

  state_e            state, state_nx;
  field_sel_t        sel, sel_nx;
  logic [SLOT_W-1:0] rev_cnt, rev_nx;
  logic [SLOT_W-1:0] tgt, tgt_nx;
  logic [SLOT_W-1:0] slot_nx;
  logic [7:0]        dout_nx, sel_addr_nx;
  logic              up_other_nx;
  logic              wr_n_last;
  logic              wr_edge;
  logic              op_hit;
  logic              busy_nx;
  logic              st_i_nx, st_ii_nx, st_iv_nx;
  logic [2:0]        grp;
  logic [4:0]        off;

  jtopl_op_wr_sched_slot_cnt #(
    .LEN    (LEN),
    .SLOT_W (SLOT_W)
  ) u_slot_cnt (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .slot    (slot),
    .zero    (zero),
    .slot_nx (slot_nx)
  );

  assign wr_edge = ~wr_n & wr_n_last;
  assign grp     = sel_addr[7:5];
  assign off     = sel_addr[4:0];
  assign op_hit  = (grp_decode(grp) != '0) && op_off_valid(off);

  assign busy      = (state == ST_PEND);
  assign up_mult   = sel.mult;
  assign up_ksl_tl = sel.ksl_tl;
  assign up_ar_dr  = sel.ar_dr;
  assign up_sl_rr  = sel.sl_rr;
  assign up_wav    = sel.wav;

  always_comb begin
    state_nx    = state;
    rev_nx      = rev_cnt;
    tgt_nx      = tgt;
    sel_nx      = sel;
    dout_nx     = dout;
    sel_addr_nx = sel_addr;
    up_other_nx = 1'b0;

    case (state)
      ST_IDLE: begin
        if (wr_edge && addr && op_hit) begin
          state_nx = ST_PEND;
          rev_nx   = '0;
          tgt_nx   = SLOT_W'(op_tgt(off));
          dout_nx  = din;
          sel_nx   = grp_decode(grp);
        end
      end
      ST_PEND: begin
        // A data write landing on the release clk still sees busy and is lost.
        if (cen) begin
          if (rev_cnt == SLOT_W'(LEN - 1)) begin
            state_nx = ST_IDLE;
            sel_nx   = '0;
          end else begin
            rev_nx = rev_cnt + SLOT_W'(1);
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (wr_edge && !addr) begin
      sel_addr_nx = din;
    end
    if (wr_edge && addr && !op_hit) begin
      up_other_nx = 1'b1;
      dout_nx     = din;
    end

    // Strobes are registered from next-state values so they line up with the
    // slot the counter is about to present.
    busy_nx  = (state_nx == ST_PEND);
    st_i_nx  = busy_nx && (slot_nx == tgt_nx);
    st_ii_nx = busy_nx && (slot_nx == wrap_add(tgt_nx, OFF_II));
    st_iv_nx = busy_nx && (slot_nx == wrap_add(tgt_nx, OFF_IV));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rev_cnt      <= '0;
      tgt          <= '0;
      sel          <= '0;
      dout         <= '0;
      sel_addr     <= '0;
      up_other     <= 1'b0;
      wr_n_last    <= 1'b1;
      update_op_I  <= 1'b0;
      update_op_II <= 1'b0;
      update_op_IV <= 1'b0;
    end else begin
      state        <= state_nx;
      rev_cnt      <= rev_nx;
      tgt          <= tgt_nx;
      sel          <= sel_nx;
      dout         <= dout_nx;
      sel_addr     <= sel_addr_nx;
      up_other     <= up_other_nx;
      wr_n_last    <= wr_n;
      update_op_I  <= st_i_nx;
      update_op_II <= st_ii_nx;
      update_op_IV <= st_iv_nx;
    end
  end

endmodule
